// File: rtl/instr_encoder_loader.sv
// Assembles symbolic instruction requests into 32-bit MIPS words and streams
// them into instruction memory, optionally padding a NOP after each branch/jump.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned PAD_DELAY_SLOT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] word_count,
    output logic              full,
    output logic              err
);

    localparam int unsigned DATA_W = 32;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    localparam logic [4:0] M_NOP  = 5'd0,  M_ADD  = 5'd1,  M_SUB  = 5'd2,  M_AND  = 5'd3;
    localparam logic [4:0] M_OR   = 5'd4,  M_XOR  = 5'd5,  M_NOR  = 5'd6,  M_SLT  = 5'd7;
    localparam logic [4:0] M_SLL  = 5'd8,  M_SRL  = 5'd9,  M_JR   = 5'd10, M_MUL  = 5'd11;
    localparam logic [4:0] M_ADDI = 5'd12, M_ANDI = 5'd13, M_ORI  = 5'd14, M_XORI = 5'd15;
    localparam logic [4:0] M_SLTI = 5'd16, M_LW   = 5'd17, M_SW   = 5'd18, M_SB   = 5'd19;
    localparam logic [4:0] M_LH   = 5'd20, M_LB   = 5'd21, M_SH   = 5'd22, M_BGEZ = 5'd23;
    localparam logic [4:0] M_BLTZ = 5'd24, M_BEQ  = 5'd25, M_BNE  = 5'd26, M_BGTZ = 5'd27;
    localparam logic [4:0] M_BLEZ = 5'd28, M_J    = 5'd29, M_JAL  = 5'd30, M_ILL  = 5'd31;

    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_REGIMM = 6'b000001, OP_MUL = 6'b011100;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LB = 6'b100000;
    localparam logic [5:0] OP_LH = 6'b100001, OP_LW = 6'b100011, OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001, OP_SW = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_JR = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010, F_MUL = 6'b000010;

    localparam logic [4:0] ZERO5 = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [1:0] {IDLE, LOAD, PAD, FULL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_d;
    logic                we_d, err_d;
    logic [DATA_W-1:0]   enc_word;
    logic                is_branch;

    function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [4:0] f_rd,
                                           input logic [4:0] f_sh, input logic [5:0] fn);
        return {op, f_rs, f_rt, f_rd, f_sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {op, f_rs, f_rt, f_imm};
    endfunction

    // Mnemonic to machine word; unused or forced fields never come from the inputs.
    always_comb begin
        enc_word  = '0;
        is_branch = 1'b0;
        case (mnem)
            M_NOP:  enc_word = '0;
            M_ADD:  enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_ADD);
            M_SUB:  enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_SUB);
            M_AND:  enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_AND);
            M_OR:   enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_OR);
            M_XOR:  enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_XOR);
            M_NOR:  enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_NOR);
            M_SLT:  enc_word = r_word(OP_SPECIAL, rs, rt, rd, ZERO5, F_SLT);
            M_SLL:  enc_word = r_word(OP_SPECIAL, ZERO5, rt, rd, shamt, F_SLL);
            M_SRL:  enc_word = r_word(OP_SPECIAL, ZERO5, rt, rd, shamt, F_SRL);
            M_JR: begin
                enc_word  = r_word(OP_SPECIAL, rs, ZERO5, ZERO5, ZERO5, F_JR);
                is_branch = 1'b1;
            end
            M_MUL:  enc_word = r_word(OP_MUL, rs, rt, rd, ZERO5, F_MUL);
            M_ADDI: enc_word = i_word(OP_ADDI, rs, rt, imm);
            M_ANDI: enc_word = i_word(OP_ANDI, rs, rt, imm);
            M_ORI:  enc_word = i_word(OP_ORI, rs, rt, imm);
            M_XORI: enc_word = i_word(OP_XORI, rs, rt, imm);
            M_SLTI: enc_word = i_word(OP_SLTI, rs, rt, imm);
            M_LW:   enc_word = i_word(OP_LW, rs, rt, imm);
            M_SW:   enc_word = i_word(OP_SW, rs, rt, imm);
            M_SB:   enc_word = i_word(OP_SB, rs, rt, imm);
            M_LH:   enc_word = i_word(OP_LH, rs, rt, imm);
            M_LB:   enc_word = i_word(OP_LB, rs, rt, imm);
            M_SH:   enc_word = i_word(OP_SH, rs, rt, imm);
            M_BGEZ: begin
                enc_word  = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
                is_branch = 1'b1;
            end
            M_BLTZ: begin
                enc_word  = i_word(OP_REGIMM, rs, ZERO5, imm);
                is_branch = 1'b1;
            end
            M_BEQ: begin
                enc_word  = i_word(OP_BEQ, rs, rt, imm);
                is_branch = 1'b1;
            end
            M_BNE: begin
                enc_word  = i_word(OP_BNE, rs, rt, imm);
                is_branch = 1'b1;
            end
            M_BGTZ: begin
                enc_word  = i_word(OP_BGTZ, rs, ZERO5, imm);
                is_branch = 1'b1;
            end
            M_BLEZ: begin
                enc_word  = i_word(OP_BLEZ, rs, ZERO5, imm);
                is_branch = 1'b1;
            end
            M_J: begin
                enc_word  = {OP_J, target};
                is_branch = 1'b1;
            end
            M_JAL: begin
                enc_word  = {OP_JAL, target};
                is_branch = 1'b1;
            end
            default: enc_word = '0;
        endcase
    end

    // Next-state and registered-output logic; start overrides everything else.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = word_count;
        err_d   = err;
        we_d    = 1'b0;
        addr_d  = wr_addr;
        data_d  = wr_data;
        if (start) begin
            state_d = LOAD;
            ptr_d   = BASE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (mnem == M_ILL) begin
                            err_d = 1'b1;
                        end else begin
                            we_d   = 1'b1;
                            addr_d = ptr_q;
                            data_d = enc_word;
                            ptr_d  = ptr_q + WORD_STEP;
                            cnt_d  = word_count + ADDR_W'(1);
                            if (word_count == LAST_CNT) begin
                                state_d = FULL;
                            end else if ((PAD_DELAY_SLOT != 0) && is_branch) begin
                                state_d = PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = '0;
                    ptr_d   = ptr_q + WORD_STEP;
                    cnt_d   = word_count + ADDR_W'(1);
                    state_d = (word_count == LAST_CNT) ? FULL : LOAD;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= BASE;
            word_count <= '0;
            err        <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            in_ready   <= 1'b0;
            full       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            word_count <= cnt_d;
            err        <= err_d;
            wr_en      <= we_d;
            wr_addr    <= addr_d;
            wr_data    <= data_d;
            in_ready   <= (state_d == LOAD);
            full       <= (state_d == FULL);
        end
    end

endmodule
